fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline core.
- Compares up to NSRC decoded source registers of the ID-stage instruction against the destinations of the instructions in EX, MEM and WB.
- Registers per-source operand-select codes for the instruction entering EX, using a nearest-producer-wins priority.
- Runs a small state machine that freezes IF/ID and injects STALL_CYC bubbles into EX on a load-use hazard.

---
 rtl/fwd_hazard_unit.sv | 125 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for the 5-stage pipeline.
// Optional WB-retire bypass (code 11) enabled by defining WB_BYPASS_EN.
module fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int NSRC      = 2,
    parameter int STALL_CYC = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 ex_wr_en,
    input  logic                 mem_wr_en,
    input  logic                 wb_wr_en,
    input  logic [AW-1:0]        ex_wr_num,
    input  logic [AW-1:0]        mem_wr_num,
    input  logic [AW-1:0]        wb_wr_num,
    input  logic                 ex_is_load,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 ex_bubble
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    localparam logic [1:0] CNT_INIT =
        (STALL_CYC > 1) ? 2'(STALL_CYC - 2) : 2'd0;

    state_t            state;
    logic [1:0]        cnt;
    logic [NSRC-1:0]   m_ex;
    logic [NSRC-1:0]   m_mem;
    logic [NSRC-1:0]   m_wb;
    logic              hazard;
    logic [2*NSRC-1:0] sel_nxt;

    // Per-source producer matches; r0 is hard-wired and never forwarded.
    always_comb begin
        m_ex  = '0;
        m_mem = '0;
        m_wb  = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic [AW-1:0] src;
            logic          rd;
            src = id_src[i*AW +: AW];
            rd  = id_valid & id_src_used[i] & (src != '0);
            m_ex[i]  = rd & ex_wr_en  & (ex_wr_num  == src);
            m_mem[i] = rd & mem_wr_en & (mem_wr_num == src);
            m_wb[i]  = rd & wb_wr_en  & (wb_wr_num  == src);
        end
    end

`ifndef WB_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^m_wb;
`endif

    // Load-use detection and stall; reset kills stall without waiting for a clock.
    always_comb begin
        hazard    = (state == IDLE) & ex_is_load & (|m_ex);
        stall     = ~reset & ((state == STALL) | hazard);
        ex_bubble = stall;
    end

    // Nearest producer wins: EX (non-load) over MEM over WB.
    always_comb begin
        sel_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (m_ex[i] && !ex_is_load)
                sel_nxt[2*i +: 2] = 2'b01;
            else if (m_mem[i])
                sel_nxt[2*i +: 2] = 2'b10;
`ifdef WB_BYPASS_EN
            else if (m_wb[i])
                sel_nxt[2*i +: 2] = 2'b11;
`endif
        end
    end

    // Stall sequencer: counts the extra bubble cycles after the detect cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hazard && (STALL_CYC > 1)) begin
                        state <= STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 2'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Operand selects for the instruction entering EX; bubbles read the regfile.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fwd_sel <= '0;
        else if (flush || stall)
            fwd_sel <= '0;
        else
            fwd_sel <= sel_nxt;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one instance with one bubble,
// one with three, sharing the same stimulus.
module tb_fwd_hazard_unit;

    localparam int AW   = 5;
    localparam int NSRC = 2;

`ifdef WB_BYPASS_EN
    localparam logic [3:0] WB_CODE = 4'b0011;
`else
    localparam logic [3:0] WB_CODE = 4'b0000;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_used;
    logic                ex_wr_en;
    logic                mem_wr_en;
    logic                wb_wr_en;
    logic [AW-1:0]       ex_wr_num;
    logic [AW-1:0]       mem_wr_num;
    logic [AW-1:0]       wb_wr_num;
    logic                ex_is_load;

    logic [2*NSRC-1:0]   sel1, sel3;
    logic                stall1, stall3;
    logic                bub1, bub3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .STALL_CYC(1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
        .ex_wr_num(ex_wr_num), .mem_wr_num(mem_wr_num), .wb_wr_num(wb_wr_num),
        .ex_is_load(ex_is_load),
        .fwd_sel(sel1), .stall(stall1), .ex_bubble(bub1)
    );

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .STALL_CYC(3)) dut3 (
        .clock(clock), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
        .ex_wr_num(ex_wr_num), .mem_wr_num(mem_wr_num), .wb_wr_num(wb_wr_num),
        .ex_is_load(ex_is_load),
        .fwd_sel(sel3), .stall(stall3), .ex_bubble(bub3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        flush       = 1'b0;
        id_valid    = 1'b0;
        id_src      = '0;
        id_src_used = '0;
        ex_wr_en    = 1'b0;
        mem_wr_en   = 1'b0;
        wb_wr_en    = 1'b0;
        ex_wr_num   = '0;
        mem_wr_num  = '0;
        wb_wr_num   = '0;
        ex_is_load  = 1'b0;
    endtask

    task automatic set_id(input logic [AW-1:0] s1, input logic [AW-1:0] s0,
                          input logic [1:0] used);
        id_valid    = 1'b1;
        id_src      = {s1, s0};
        id_src_used = used;
    endtask

    initial begin
        reset = 1'b1;
        clear();
        #2;
        chk("rst_sel1", 32'(sel1), 32'h0);
        chk("rst_sel3", 32'(sel3), 32'h0);
        chk("rst_stall1", 32'(stall1), 32'h0);
        chk("rst_stall3", 32'(stall3), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_hold_sel", 32'(sel1), 32'h0);

        // ALU chain: EX writes r8, ID reads r8 and r9
        set_id(5'd9, 5'd8, 2'b11);
        ex_wr_en  = 1'b1;
        ex_wr_num = 5'd8;
        #1;
        chk("alu_stall_pre", 32'(stall1), 32'h0);
        tick();
        chk("alu_sel", 32'(sel1), 32'h1);
        chk("alu_sel3", 32'(sel3), 32'h1);
        chk("alu_stall", 32'(stall1), 32'h0);

        // src1 matches MEM while src0 matches EX
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd9;
        tick();
        chk("two_src", 32'(sel1), 32'h9);

        // Priority: EX and MEM both write r3
        clear();
        set_id(5'd0, 5'd3, 2'b01);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd3;
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd3;
        tick();
        chk("prio_ex", 32'(sel1), 32'h1);
        ex_wr_en = 1'b0;
        tick();
        chk("prio_mem", 32'(sel1), 32'h2);

        // Unused source never forwards
        id_src_used = 2'b00;
        tick();
        chk("unused_src", 32'(sel1), 32'h0);

        // Register zero never matches, even for a load
        clear();
        set_id(5'd0, 5'd0, 2'b11);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd0;
        ex_is_load = 1'b1;
        #1;
        chk("r0_stall", 32'(stall1), 32'h0);
        chk("r0_stall3", 32'(stall3), 32'h0);
        tick();
        chk("r0_sel", 32'(sel1), 32'h0);

        // WB match on r12; also WB loses to MEM
        clear();
        set_id(5'd0, 5'd12, 2'b01);
        wb_wr_en  = 1'b1;
        wb_wr_num = 5'd12;
        tick();
        chk("wb_sel", 32'(sel1), 32'(WB_CODE));
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd12;
        tick();
        chk("wb_vs_mem", 32'(sel1), 32'h2);
        id_valid = 1'b0;
        tick();
        chk("id_invalid", 32'(sel1), 32'h0);

        // Load-use: EX load to r5, ID reads r5
        clear();
        set_id(5'd0, 5'd5, 2'b01);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd5;
        ex_is_load = 1'b1;
        #1;
        chk("lu_stall_c0", 32'(stall1), 32'h1);
        chk("lu_bubble_c0", 32'(bub1), 32'h1);
        chk("lu_stall3_c0", 32'(stall3), 32'h1);
        tick();
        ex_wr_en   = 1'b0;
        ex_is_load = 1'b0;
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd5;
        #1;
        chk("lu_stall_c1", 32'(stall1), 32'h0);
        chk("lu_sel_bubble", 32'(sel1), 32'h0);
        chk("lu_stall3_c1", 32'(stall3), 32'h1);
        tick();
        chk("lu_sel_mem", 32'(sel1), 32'h2);
        chk("lu_stall3_c2", 32'(stall3), 32'h1);
        chk("lu_sel3_c2", 32'(sel3), 32'h0);
        tick();
        chk("lu_stall3_c3", 32'(stall3), 32'h0);
        chk("lu_sel3_c3", 32'(sel3), 32'h0);
        tick();
        chk("lu_sel3_mem", 32'(sel3), 32'h2);

        // Flush in second stall cycle of the 3-cycle unit
        clear();
        set_id(5'd0, 5'd5, 2'b01);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd5;
        ex_is_load = 1'b1;
        tick();
        ex_wr_num  = 5'd6;
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd5;
        flush      = 1'b1;
        #1;
        chk("fl_stall3_pre", 32'(stall3), 32'h1);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_stall3_post", 32'(stall3), 32'h0);
        chk("fl_sel3", 32'(sel3), 32'h0);
        chk("fl_sel1", 32'(sel1), 32'h0);

        // Hazard and flush together: flush wins
        clear();
        set_id(5'd0, 5'd5, 2'b01);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd5;
        ex_is_load = 1'b1;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        ex_wr_num  = 5'd6;
        #1;
        chk("hf_stall3", 32'(stall3), 32'h0);
        chk("hf_sel3", 32'(sel3), 32'h0);

        // Asynchronous reset in the middle of a stall
        clear();
        set_id(5'd0, 5'd5, 2'b01);
        ex_wr_en   = 1'b1;
        ex_wr_num  = 5'd5;
        ex_is_load = 1'b1;
        mem_wr_en  = 1'b1;
        mem_wr_num = 5'd5;
        tick();
        ex_wr_en   = 1'b0;
        ex_is_load = 1'b0;
        tick();
        chk("ar_stall3_pre", 32'(stall3), 32'h1);
        chk("ar_sel1_pre", 32'(sel1), 32'h2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_stall3", 32'(stall3), 32'h0);
        chk("ar_bub3", 32'(bub3), 32'h0);
        chk("ar_sel1", 32'(sel1), 32'h0);
        chk("ar_sel3", 32'(sel3), 32'h0);
        tick();
        reset = 1'b0;
        clear();
        tick();
        chk("ar_after", 32'(stall3), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
